// File: rtl/mcu_isa_pkg.sv
// Shared ISA definitions for the MCU front end: opcodes, instruction fields,
// fetch FSM encoding and the IF/ID payload type.
package mcu_isa_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 17;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD = 5'b00001;
  localparam logic [OP_W-1:0] OP_ANI = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADI = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_SLT = 5'b00101;
  localparam logic [OP_W-1:0] OP_IN  = 5'b00110;
  localparam logic [OP_W-1:0] OP_OUT = 5'b00111;
  localparam logic [OP_W-1:0] OP_NOT = 5'b01000;
  localparam logic [OP_W-1:0] OP_LD  = 5'b01001;
  localparam logic [OP_W-1:0] OP_ST  = 5'b01010;
  localparam logic [OP_W-1:0] OP_MOV = 5'b01011;
  localparam logic [OP_W-1:0] OP_JMP = 5'b01100;
  localparam logic [OP_W-1:0] OP_JMR = 5'b01101;
  localparam logic [OP_W-1:0] OP_JML = 5'b01110;
  localparam logic [OP_W-1:0] OP_ORI = 5'b01111;
  localparam logic [OP_W-1:0] OP_XOR = 5'b10000;
  localparam logic [OP_W-1:0] OP_LSR = 5'b11100;
  localparam logic [OP_W-1:0] OP_LSL = 5'b11101;
  localparam logic [OP_W-1:0] OP_BZ  = 5'b11110;
  localparam logic [OP_W-1:0] OP_BNZ = 5'b11111;

  localparam logic [INSTR_W-1:0] NOP_WORD = 17'h00000;

  localparam int unsigned OPC_MSB = 16;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned DR_MSB  = 11;
  localparam int unsigned DR_LSB  = 9;
  localparam int unsigned DA_MSB  = 8;
  localparam int unsigned DA_LSB  = 6;
  localparam int unsigned DB_MSB  = 5;
  localparam int unsigned DB_LSB  = 3;
  localparam int unsigned SH_MSB  = 2;
  localparam int unsigned SH_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fsm_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD    = 2'b00,
    IFID_CLEAR   = 2'b01,
    IFID_CAPTURE = 2'b10
  } ifid_op_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifid_t;

  // Assemble an instruction word from its fields.
  function automatic logic [INSTR_W-1:0] mk_instr(input logic [OP_W-1:0] op,
                                                  input logic [REG_W-1:0] dr,
                                                  input logic [REG_W-1:0] da,
                                                  input logic [REG_W-1:0] db,
                                                  input logic [REG_W-1:0] sh);
    return {op, dr, da, db, sh};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control inputs, program-memory port, redirect and IF/ID outputs.
interface instr_fetch_unit_if
  import mcu_isa_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic               start;
  logic               halt;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_addr;
  logic [PC_W-1:0]    pm_addr;
  logic [INSTR_W-1:0] pm_instr;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic [OP_W-1:0]    if_opcode;
  logic [REG_W-1:0]   if_dr;
  logic [REG_W-1:0]   if_da;
  logic [REG_W-1:0]   if_db;
  logic [REG_W-1:0]   if_sh;
  logic               pc_wrap;
  logic [CNT_W-1:0]   fetch_cnt;

  modport master (
    input  start, halt, stall, redirect_valid, redirect_addr, pm_instr,
    output pm_addr, if_valid, if_pc, if_instr, if_opcode, if_dr, if_da,
           if_db, if_sh, pc_wrap, fetch_cnt
  );

  modport slave (
    output start, halt, stall, redirect_valid, redirect_addr, pm_instr,
    input  pm_addr, if_valid, if_pc, if_instr, if_opcode, if_dr, if_da,
           if_db, if_sh, pc_wrap, fetch_cnt
  );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: redirect load, sequential advance with 8-bit wrap detect.
module fetch_pc
  import mcu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_addr,
  input  logic            advance,
  output logic [PC_W-1:0] pc,
  output logic            pc_wrap
);

  logic [PC_W-1:0] pc_q;
  logic            wrap_q;

  // Redirect wins over advance; wrap only flags a sequential 255 -> 0 step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (load) begin
        pc_q <= load_addr;
      end else if (advance) begin
        pc_q   <= pc_q + PC_W'(1);
        wrap_q <= (pc_q == '1);
      end
    end
  end

  assign pc      = pc_q;
  assign pc_wrap = wrap_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: run/halt FSM, IF/ID register with split fields,
// saturating fetch counter; PC handling lives in fetch_pc.
module instr_fetch_unit
  import mcu_isa_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int unsigned     CNT_W    = 16
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);

  fsm_state_t      state_q, state_d;
  ifid_op_t        ifid_op_c;
  logic            pc_load_c;
  logic            pc_adv_c;
  logic [PC_W-1:0] pc_q;
  logic            pc_wrap_q;
  ifid_t           ifid_q;
  logic            if_valid_q;
  logic [CNT_W-1:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Halt beats redirect for the state, but a redirect still loads the PC.
  always_comb begin
    state_d   = state_q;
    ifid_op_c = IFID_HOLD;
    pc_load_c = 1'b0;
    pc_adv_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        ifid_op_c = IFID_CLEAR;
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_load_c = bus.redirect_valid;
        if (bus.halt) begin
          state_d   = ST_HALT;
          ifid_op_c = IFID_CLEAR;
        end else if (bus.redirect_valid) begin
          ifid_op_c = IFID_CLEAR;
        end else if (!bus.stall) begin
          ifid_op_c = IFID_CAPTURE;
          pc_adv_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load_c),
    .load_addr (bus.redirect_addr),
    .advance   (pc_adv_c),
    .pc        (pc_q),
    .pc_wrap   (pc_wrap_q)
  );

  // A squashed slot keeps its pc but carries the NOP word and no valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q      <= '0;
      if_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      case (ifid_op_c)
        IFID_CAPTURE: begin
          ifid_q.instr <= bus.pm_instr;
          ifid_q.pc    <= pc_q;
          if_valid_q   <= 1'b1;
          if (fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
        end
        IFID_CLEAR: begin
          ifid_q.instr <= NOP_WORD;
          if_valid_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.pm_addr   = pc_q;
  assign bus.pc_wrap   = pc_wrap_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = ifid_q.pc;
  assign bus.if_instr  = ifid_q.instr;
  assign bus.if_opcode = ifid_q.instr[OPC_MSB:OPC_LSB];
  assign bus.if_dr     = ifid_q.instr[DR_MSB:DR_LSB];
  assign bus.if_da     = ifid_q.instr[DA_MSB:DA_LSB];
  assign bus.if_db     = ifid_q.instr[DB_MSB:DB_LSB];
  assign bus.if_sh     = ifid_q.instr[SH_MSB:SH_LSB];
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational program-memory model.
module tb_instr_fetch_unit;
  import mcu_isa_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   npass  = 0;
  int   nfail  = 0;
  int   ntotal = 0;

  logic [16:0] mem [256];

  instr_fetch_unit_if #(.CNT_W(16)) bus ();

  instr_fetch_unit #(
    .RESET_PC (8'h00),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.pm_instr = mem[bus.pm_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pm_addr"},   32'(bus.pm_addr),   32'h00);
    chk({tag, "_if_valid"},  32'(bus.if_valid),  32'h0);
    chk({tag, "_if_pc"},     32'(bus.if_pc),     32'h0);
    chk({tag, "_if_instr"},  32'(bus.if_instr),  32'h0);
    chk({tag, "_if_opcode"}, 32'(bus.if_opcode), 32'h0);
    chk({tag, "_if_sh"},     32'(bus.if_sh),     32'h0);
    chk({tag, "_pc_wrap"},   32'(bus.pc_wrap),   32'h0);
    chk({tag, "_fetch_cnt"}, 32'(bus.fetch_cnt), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'h01000 | 17'(i);
    mem[0] = mk_instr(5'b00110, 3'd1, 3'd0, 3'd0, 3'd0);
    mem[1] = mk_instr(5'b11101, 3'd2, 3'd1, 3'd0, 3'd4);
    mem[5] = mk_instr(5'b01101, 3'd3, 3'd2, 3'd1, 3'd0);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("reset");

    // start-up fetch
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_e1_valid", 32'(bus.if_valid), 32'h0);
    chk("start_e1_pm_addr", 32'(bus.pm_addr), 32'h00);
    tick();
    chk("start_e2_valid", 32'(bus.if_valid), 32'h1);
    chk("start_e2_pc", 32'(bus.if_pc), 32'h00);
    chk("start_e2_opcode", 32'(bus.if_opcode), 32'h06);
    chk("start_e2_dr", 32'(bus.if_dr), 32'h1);
    chk("start_e2_pm_addr", 32'(bus.pm_addr), 32'h01);
    chk("start_e2_cnt", 32'(bus.fetch_cnt), 32'd1);
    tick();
    chk("seq1_pc", 32'(bus.if_pc), 32'h01);
    chk("seq1_opcode", 32'(bus.if_opcode), 32'h1D);
    chk("seq1_dr", 32'(bus.if_dr), 32'h2);
    chk("seq1_da", 32'(bus.if_da), 32'h1);
    chk("seq1_db", 32'(bus.if_db), 32'h0);
    chk("seq1_sh", 32'(bus.if_sh), 32'h4);
    tick();
    chk("seq2_instr", 32'(bus.if_instr), 32'h01002);
    tick();
    chk("seq3_pc", 32'(bus.if_pc), 32'h03);
    chk("seq3_pm_addr", 32'(bus.pm_addr), 32'h04);
    chk("seq3_cnt", 32'(bus.fetch_cnt), 32'd4);

    // stall for three cycles
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pm_addr", 32'(bus.pm_addr), 32'h04);
      chk("stall_if_pc", 32'(bus.if_pc), 32'h03);
      chk("stall_valid", 32'(bus.if_valid), 32'h1);
      chk("stall_cnt", 32'(bus.fetch_cnt), 32'd4);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_pc", 32'(bus.if_pc), 32'h04);
    chk("unstall_instr", 32'(bus.if_instr), 32'h01004);
    chk("unstall_cnt", 32'(bus.fetch_cnt), 32'd5);

    // redirect beats stall
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'h05;
    tick();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("redir_valid", 32'(bus.if_valid), 32'h0);
    chk("redir_instr", 32'(bus.if_instr), 32'h0);
    chk("redir_pm_addr", 32'(bus.pm_addr), 32'h05);
    chk("redir_cnt", 32'(bus.fetch_cnt), 32'd5);
    tick();
    chk("redir_tgt_valid", 32'(bus.if_valid), 32'h1);
    chk("redir_tgt_pc", 32'(bus.if_pc), 32'h05);
    chk("redir_tgt_opcode", 32'(bus.if_opcode), 32'h0D);

    // wrap at 255
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'hFF;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_load_pm_addr", 32'(bus.pm_addr), 32'hFF);
    chk("wrap_load_no_wrap", 32'(bus.pc_wrap), 32'h0);
    tick();
    chk("wrap_pc", 32'(bus.if_pc), 32'hFF);
    chk("wrap_pm_addr", 32'(bus.pm_addr), 32'h00);
    chk("wrap_pulse", 32'(bus.pc_wrap), 32'h1);
    chk("wrap_cnt", 32'(bus.fetch_cnt), 32'd7);
    tick();
    chk("wrap_pulse_end", 32'(bus.pc_wrap), 32'h0);
    chk("wrap_next_pc", 32'(bus.if_pc), 32'h00);

    // redirect from 255 must not flag a wrap
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = 8'hFF;
    tick();
    bus.redirect_addr = 8'h07;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_ff_no_wrap", 32'(bus.pc_wrap), 32'h0);
    chk("halt_setup_pm_addr", 32'(bus.pm_addr), 32'h07);

    // halt / resume
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("halt_valid", 32'(bus.if_valid), 32'h0);
    chk("halt_pm_addr", 32'(bus.pm_addr), 32'h07);
    chk("halt_instr", 32'(bus.if_instr), 32'h0);
    tick();
    chk("halt_hold_pm_addr", 32'(bus.pm_addr), 32'h07);
    chk("halt_hold_cnt", 32'(bus.fetch_cnt), 32'd8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("resume_e1_valid", 32'(bus.if_valid), 32'h0);
    tick();
    chk("resume_valid", 32'(bus.if_valid), 32'h1);
    chk("resume_pc", 32'(bus.if_pc), 32'h07);
    chk("resume_pm_addr", 32'(bus.pm_addr), 32'h08);
    chk("resume_cnt", 32'(bus.fetch_cnt), 32'd9);
    tick();

    // async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_pm_addr", 32'(bus.pm_addr), 32'h00);
    chk("post_rst_valid", 32'(bus.if_valid), 32'h0);
    chk("post_rst_idle_cnt", 32'(bus.fetch_cnt), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("post_rst_fetch_pc", 32'(bus.if_pc), 32'h00);
    chk("post_rst_fetch_valid", 32'(bus.if_valid), 32'h1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of the program memory. Holds the 8-bit program counter and drives it as the program-memory address. Captures the returned 17-bit instruction word into an IF/ID pipeline register with pre-split fields for the decoder. Handles run/halt control, stall, and redirect (jump/branch) with wrong-path squash.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `CNT_W`, default 16: width of the saturating fetched-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level; in IDLE or HALT, moves FSM to RUN.
- `halt`  in  1  level; in RUN, moves FSM to HALT.
- `stall`  in  1  decoder back-pressure; holds PC and IF/ID.
- `redirect_valid`  in  1  jump/branch taken, from downstream.
- `redirect_addr`  in  8  target PC.
- `pm_addr`  out  8  program-memory address; equals the PC register.
- `pm_instr`  in  17  instruction word from program memory (combinational read).
- `if_valid`  out  1  IF/ID holds a real instruction.
- `if_pc`  out  8  PC of the held instruction.
- `if_instr`  out  17  held instruction word.
- `if_opcode`  out  5  `if_instr[16:12]`.
- `if_dr`  out  3  `if_instr[11:9]`.
- `if_da`  out  3  `if_instr[8:6]`.
- `if_db`  out  3  `if_instr[5:3]`.
- `if_sh`  out  3  `if_instr[2:0]`, shift amount or immediate.
- `pc_wrap`  out  1  one-cycle pulse when PC wraps from 255 to 0.
- `fetch_cnt`  out  CNT_W  count of valid instructions latched; saturates at all-ones.

## Operation
- FSM states: IDLE (after reset), RUN, HALT.
  - IDLE: `start`=1 → RUN.
  - RUN: `halt`=1 → HALT. `halt` takes priority over a redirect in the same cycle, but the redirect PC is still loaded.
  - HALT: `start`=1 → RUN.
- Only RUN fetches. In IDLE and HALT:
  - PC holds.
  - `if_valid` is 0, and `if_instr` holds the NOP word, 17'h00000.
- Per-cycle priority in RUN:
  1. `redirect_valid`: PC ← `redirect_addr`. IF/ID ← NOP with `if_valid`=0, which squashes the wrong-path fetch. This wins over `stall`.
  2. `stall`: PC and IF/ID hold unchanged, including `if_valid`.
  3. Otherwise: IF/ID ← {`pm_instr`, PC}, `if_valid`=1, PC ← PC+1.
- PC arithmetic is 8-bit modulo. 255+1 = 0 and asserts `pc_wrap` for the next cycle only. A redirect never asserts `pc_wrap`.
- `fetch_cnt` increments on every rule-3 capture and saturates at 2^CNT_W−1.
- Field outputs are pure slices of the registered `if_instr`; the block adds no extra logic to them.
- Reset values:
  - PC = `RESET_PC`, so `pm_addr` = `RESET_PC`.
  - `if_valid` = 0, `if_pc` = 0, `if_instr` = 0 (all fields 0).
  - `pc_wrap` = 0, `fetch_cnt` = 0, state = IDLE.
- Reset asserted mid-operation clears everything immediately, regardless of `clk`.

## Timing
- `pm_addr` changes only on clock edges (or async reset); `pm_instr` must settle within the same cycle.
- Fetch latency: the instruction at PC p appears on `if_instr` one edge after p is driven on `pm_addr`.
- The edge that samples `start` moves FSM to RUN. The first capture happens on the following edge, so `if_valid` rises 2 edges after `start` is sampled high from IDLE.
- Redirect: edge E loads the target. `if_valid`=0 for the cycle after E. The target instruction is valid after E+1.
- Sustained throughput is one instruction per cycle with no stall or redirect.
- No combinational path from any input to any output. `pm_addr`, `if_*`, `pc_wrap` and `fetch_cnt` are all registered.

## Structure
- Shared package `mcu_isa_pkg` holds:
  - the 5-bit opcode constants (NOP, ADD, ANI, ADI, SUB, SLT, IN, OUT, NOT, LD, ST, MOV, JMP, JMR, JML, ORI, XOR, LSR, LSL, BZ, BNZ);
  - the 17-bit `NOP_WORD`;
  - field MSB/LSB constants;
  - the FSM state encoding.
- One sub-module, `fetch_pc`, holds the PC register, increment/redirect mux, wrap detect and hold enable. The top level holds the FSM, the IF/ID register and `fetch_cnt`.

## Test plan
- **Start-up fetch.** Reset, then `start`=1 for one cycle, with a memory model returning {IN,1,0,0,0} at 0 and {LSL,2,1,0,4} at 1.
  - `if_valid` rises 2 edges later with `if_pc`=0 and `if_opcode`=5'b00110.
  - Next cycle: `if_pc`=1, `if_opcode`=5'b11101, `if_sh`=4.
- **Stall.** At `if_pc`=3, hold `stall`=1 for 3 cycles.
  - `pm_addr` stays 4 and `if_pc` stays 3 throughout.
  - `fetch_cnt` is unchanged.
  - After release, `if_pc`=4 follows.
- **Redirect beats stall.** `stall`=1 and `redirect_valid`=1 with `redirect_addr`=8'h05 in the same cycle.
  - Next cycle: `if_valid`=0 and `if_instr`=0.
  - Following cycle: `if_pc`=5 with `if_opcode`=JMR (5'b01101).
- **Wrap.** Redirect to 8'hFF, then run.
  - After capturing pc 255, `pm_addr`=0 and `pc_wrap` pulses high for exactly one cycle.
- **Halt/resume.** Assert `halt` when `pm_addr`=7.
  - `if_valid`=0 and `pm_addr` stays 7.
  - On `start`, fetch resumes with `if_pc`=7.
- **Async reset mid-run.** Assert `rst` between clock edges while running.
  - All outputs take their reset values immediately.
  - After release, state is IDLE and `pm_addr` equals `RESET_PC`.
